// File: rtl/pkt_pkg.sv
// rtl/pkt_pkg.sv - shared types and constants for the packet checker
package pkt_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  localparam int ERR_LEN     = 0;
  localparam int ERR_SEQ     = 1;
  localparam int ERR_DUP_SOP = 2;
  localparam int ERR_LEN_OVF = 3;

  // Also used by fifo_p and the packet generator.
  localparam int DEF_MIN_LEN = 64;
  localparam int DEF_MAX_LEN = 256;

endpackage

// File: rtl/pkt_chk_if.sv
// rtl/pkt_chk_if.sv - byte stream in, report and statistics out
interface pkt_chk_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 12,
  parameter int CNT_W  = 16
);
  logic              din_vld;
  logic              din_sop;
  logic              din_eop;
  logic [DATA_W-1:0] din;
  logic              rpt_vld;
  logic [LEN_W-1:0]  rpt_len;
  logic [3:0]        rpt_err;
  logic              stray_err;
  logic [CNT_W-1:0]  pkt_cnt;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output din_vld, din_sop, din_eop, din,
    input  rpt_vld, rpt_len, rpt_err, stray_err, pkt_cnt, err_cnt
  );

  modport slave (
    input  din_vld, din_sop, din_eop, din,
    output rpt_vld, rpt_len, rpt_err, stray_err, pkt_cnt, err_cnt
  );
endinterface

// File: rtl/sat_cnt.sv
// rtl/sat_cnt.sv - saturating counter stepping by 0, 1 (inc) or 2 (inc2)
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         inc2,
  output logic [W-1:0] cnt
);
  logic [W+1:0] sum;

  assign sum = {2'b00, cnt} + {{W{1'b0}}, inc2, inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (|sum[W+1:W]) begin
      cnt <= '1;
    end else begin
      cnt <= sum[W-1:0];
    end
  end
endmodule

// File: rtl/pkt_chk.sv
// rtl/pkt_chk.sv - framing, length and incrementing-payload checker with per-packet reports
module pkt_chk
  import pkt_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 12,
  parameter int MIN_LEN = DEF_MIN_LEN,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  pkt_chk_if.slave   bus
);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0]  LEN_MIN  = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [DATA_W-1:0] BYTE_ONE = DATA_W'(1);

  function automatic logic len_bad(input logic [LEN_W-1:0] l);
    return (l < LEN_MIN) || (l > LEN_MAX);
  endfunction

  function automatic logic [3:0] mk_err(input logic lb, input logic seq,
                                        input logic dup, input logic ovf);
    logic [3:0] e;
    e              = '0;
    e[ERR_LEN]     = lb;
    e[ERR_SEQ]     = seq;
    e[ERR_DUP_SOP] = dup;
    e[ERR_LEN_OVF] = ovf;
    return e;
  endfunction

  state_t             state, state_d;
  logic [LEN_W-1:0]   len, len_d, len_inc;
  logic [DATA_W-1:0]  prev, prev_d;
  logic               seq_acc, seq_d, seq_inc;
  logic               ovf_acc, ovf_d, ovf_inc;
  logic               start;
  logic               r0_vld, r1_vld;
  logic [LEN_W-1:0]   r0_len;
  logic [3:0]         r0_err, r1_err;
  logic               hold_vld, hold_vld_d;
  logic [LEN_W-1:0]   hold_len, hold_len_d;
  logic [3:0]         hold_err, hold_err_d;
  logic               rpt_vld, rpt_vld_d;
  logic [LEN_W-1:0]   rpt_len, rpt_len_d;
  logic [3:0]         rpt_err, rpt_err_d;
  logic               stray, stray_d;
  logic               err_rpt;

  assign len_inc = (len == '1) ? len : len + LEN_ONE;
  assign ovf_inc = ovf_acc | (len == '1);
  assign seq_inc = seq_acc | (bus.din != prev + BYTE_ONE);

  always_comb begin
    state_d    = state;
    len_d      = len;
    prev_d     = prev;
    seq_d      = seq_acc;
    ovf_d      = ovf_acc;
    start      = 1'b0;
    stray_d    = 1'b0;
    r0_vld     = 1'b0;
    r0_len     = '0;
    r0_err     = '0;
    r1_vld     = 1'b0;
    r1_err     = '0;
    hold_vld_d = 1'b0;
    hold_len_d = '0;
    hold_err_d = '0;
    rpt_vld_d  = 1'b0;
    rpt_len_d  = '0;
    rpt_err_d  = '0;

    if (bus.din_vld) begin
      case (state)
        IDLE: begin
          if (bus.din_sop) start = 1'b1;
          else             stray_d = 1'b1;
        end
        IN_PKT: begin
          if (bus.din_sop) begin
            r0_vld = 1'b1;
            r0_len = len;
            r0_err = mk_err(len_bad(len), seq_acc, 1'b1, ovf_acc);
            start  = 1'b1;
          end else begin
            len_d  = len_inc;
            prev_d = bus.din;
            seq_d  = seq_inc;
            ovf_d  = ovf_inc;
            if (bus.din_eop) begin
              r0_vld  = 1'b1;
              r0_len  = len_inc;
              r0_err  = mk_err(len_bad(len_inc), seq_inc, 1'b0, ovf_inc);
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A sop byte seeds a new packet; a sop+eop byte is a whole packet on its own.
    if (start) begin
      prev_d = bus.din;
      len_d  = LEN_ONE;
      seq_d  = 1'b0;
      ovf_d  = 1'b0;
      if (bus.din_eop) begin
        state_d = IDLE;
        if (r0_vld) begin
          r1_vld = 1'b1;
          r1_err = mk_err(len_bad(LEN_ONE), 1'b0, 1'b0, 1'b0);
        end else begin
          r0_vld = 1'b1;
          r0_len = LEN_ONE;
          r0_err = mk_err(len_bad(LEN_ONE), 1'b0, 1'b0, 1'b0);
        end
      end else begin
        state_d = IN_PKT;
      end
    end

    // Second report of an abort+single byte waits one cycle in the hold slot.
    if (hold_vld) begin
      rpt_vld_d  = 1'b1;
      rpt_len_d  = hold_len;
      rpt_err_d  = hold_err;
      hold_vld_d = r0_vld;
      hold_len_d = r0_len;
      hold_err_d = r0_err;
    end else begin
      rpt_vld_d  = r0_vld;
      rpt_len_d  = r0_len;
      rpt_err_d  = r0_err;
      hold_vld_d = r1_vld;
      hold_len_d = LEN_ONE;
      hold_err_d = r1_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len      <= '0;
      prev     <= '0;
      seq_acc  <= 1'b0;
      ovf_acc  <= 1'b0;
      hold_vld <= 1'b0;
      hold_len <= '0;
      hold_err <= '0;
      rpt_vld  <= 1'b0;
      rpt_len  <= '0;
      rpt_err  <= '0;
      stray    <= 1'b0;
    end else begin
      state    <= state_d;
      len      <= len_d;
      prev     <= prev_d;
      seq_acc  <= seq_d;
      ovf_acc  <= ovf_d;
      hold_vld <= hold_vld_d;
      hold_len <= hold_len_d;
      hold_err <= hold_err_d;
      rpt_vld  <= rpt_vld_d;
      rpt_len  <= rpt_len_d;
      rpt_err  <= rpt_err_d;
      stray    <= stray_d;
    end
  end

  assign err_rpt = rpt_vld_d && (rpt_err_d != 4'd0);

  sat_cnt #(.W(CNT_W)) u_pkt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rpt_vld_d),
    .inc2  (1'b0),
    .cnt   (bus.pkt_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_rpt ^ stray_d),
    .inc2  (err_rpt & stray_d),
    .cnt   (bus.err_cnt)
  );

  assign bus.rpt_vld   = rpt_vld;
  assign bus.rpt_len   = rpt_len;
  assign bus.rpt_err   = rpt_err;
  assign bus.stray_err = stray;
endmodule
